// File: rtl/csm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | csm_pkg : shared command encoding for the computation-storage core |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package csm_pkg;

  typedef enum logic [1:0] {
    RD_MEM_CMD = 2'b00,
    WR_MEM_CMD = 2'b01,
    ADD_CMD    = 2'b10,
    SUB_CMD    = 2'b11
  } cmd_e;

  function automatic logic produces_result(input cmd_e cmd);
    return cmd != WR_MEM_CMD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO with occupancy count     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; an empty FIFO presents zero instead.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign data_o  = empty_o ? T'('0) : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cmd_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cmd_issue_queue : buffers host commands, issues them to the core  |
// | and returns tagged results in order with credit-based flow control |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cmd_issue_queue
  import csm_pkg::*;
#(
  parameter int unsigned MEM_WIDTH  = 8,
  parameter int unsigned MEM_LENGTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RES_DEPTH  = 4,
  parameter int unsigned CORE_LAT   = 2,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_cmd,
  input  logic [MEM_LENGTH-1:0]    in_addA,
  input  logic [MEM_LENGTH-1:0]    in_addB,
  input  logic [MEM_LENGTH-1:0]    in_addC,
  input  logic [MEM_WIDTH-1:0]     in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [1:0]               core_cmd,
  output logic [MEM_LENGTH-1:0]    core_addA,
  output logic [MEM_LENGTH-1:0]    core_addB,
  output logic [MEM_LENGTH-1:0]    core_addC,
  output logic [MEM_WIDTH-1:0]     core_DQ_i,
  output logic                     core_issue,
  input  logic [MEM_WIDTH-1:0]     core_DQ_o,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [MEM_WIDTH-1:0]     res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned RCW           = $clog2(RES_DEPTH) + 1;
  localparam logic [RCW:0] CREDIT_LIMIT = (RCW+1)'(RES_DEPTH);

  typedef struct packed {
    cmd_e                  cmd;
    logic [MEM_LENGTH-1:0] addA;
    logic [MEM_LENGTH-1:0] addB;
    logic [MEM_LENGTH-1:0] addC;
    logic [MEM_WIDTH-1:0]  data;
    logic [TAG_W-1:0]      tag;
  } csm_cmd_t;

  typedef struct packed {
    logic [MEM_WIDTH-1:0] data;
    logic [TAG_W-1:0]     tag;
  } res_t;

  typedef struct packed {
    logic             want;
    logic [TAG_W-1:0] tag;
  } pipe_t;

  logic                  accept_q;
  logic                  cq_push;
  logic                  cq_full;
  logic                  cq_empty;
  logic [$clog2(DEPTH):0] cq_count;
  csm_cmd_t              cq_in;
  csm_cmd_t              head;

  res_t                  rq_in;
  res_t                  rq_head;
  logic                  rq_push;
  logic                  rq_pop;
  logic                  rq_full;
  logic                  rq_empty;
  logic [RCW-1:0]        rq_count;

  pipe_t                 pipe_q [CORE_LAT];
  pipe_t                 pipe_in;
  logic                  capture;
  logic [RCW-1:0]        inflight_q;
  logic [RCW-1:0]        inflight_d;
  logic [RCW:0]          committed;
  logic                  head_wants;
  logic                  issue;

  cmd_e                  core_cmd_q;
  logic [MEM_LENGTH-1:0] core_addA_q;
  logic [MEM_LENGTH-1:0] core_addB_q;
  logic [MEM_LENGTH-1:0] core_addC_q;
  logic [MEM_WIDTH-1:0]  core_DQ_i_q;
  logic                  core_issue_q;

  always_ff @(posedge clk) begin
    if (!rst) accept_q <= 1'b0;
    else      accept_q <= 1'b1;
  end

  assign in_ready = accept_q && !cq_full;
  assign cq_push  = in_valid && in_ready;

  always_comb begin
    cq_in      = '0;
    cq_in.cmd  = cmd_e'(in_cmd);
    cq_in.addA = in_addA;
    cq_in.addB = in_addB;
    cq_in.addC = in_addC;
    cq_in.data = in_data;
    cq_in.tag  = in_tag;
  end

  sync_fifo #(.T(csm_cmd_t), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cq_push),
    .data_i  (cq_in),
    .pop_i   (issue),
    .data_o  (head),
    .full_o  (cq_full),
    .empty_o (cq_empty),
    .count_o (cq_count)
  );

  // Results already promised (in the pipe or queued) must never exceed the result FIFO.
  assign head_wants = produces_result(head.cmd);
  assign committed  = {1'b0, inflight_q} + {1'b0, rq_count};
  assign issue      = !cq_empty && (!head_wants || (committed < CREDIT_LIMIT));

  always_ff @(posedge clk) begin
    if (!rst || !issue) begin
      core_cmd_q   <= RD_MEM_CMD;
      core_addA_q  <= '0;
      core_addB_q  <= '0;
      core_addC_q  <= '0;
      core_DQ_i_q  <= '0;
      core_issue_q <= 1'b0;
    end else begin
      core_cmd_q   <= head.cmd;
      core_addA_q  <= head.addA;
      core_addB_q  <= head.addB;
      core_addC_q  <= head.addC;
      core_DQ_i_q  <= head.data;
      core_issue_q <= 1'b1;
    end
  end

  always_comb begin
    pipe_in = '0;
    if (issue) begin
      pipe_in.want = head_wants;
      pipe_in.tag  = head.tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CORE_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_in;
      for (int unsigned i = 1; i < CORE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign capture   = pipe_q[CORE_LAT-1].want;
  assign rq_push   = capture && !rq_full;
  assign rq_in.data = core_DQ_o;
  assign rq_in.tag  = pipe_q[CORE_LAT-1].tag;

  always_comb begin
    inflight_d = inflight_q;
    if (issue && head_wants) inflight_d = inflight_d + RCW'(1);
    if (capture)             inflight_d = inflight_d - RCW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) inflight_q <= '0;
    else      inflight_q <= inflight_d;
  end

  sync_fifo #(.T(res_t), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rq_push),
    .data_i  (rq_in),
    .pop_i   (rq_pop),
    .data_o  (rq_head),
    .full_o  (rq_full),
    .empty_o (rq_empty),
    .count_o (rq_count)
  );

  assign res_valid  = !rq_empty;
  assign rq_pop     = res_valid && res_ready;
  assign res_data   = rq_head.data;
  assign res_tag    = rq_head.tag;
  assign q_count    = cq_count;

  assign core_cmd   = core_cmd_q;
  assign core_addA  = core_addA_q;
  assign core_addB  = core_addB_q;
  assign core_addC  = core_addC_q;
  assign core_DQ_i  = core_DQ_i_q;
  assign core_issue = core_issue_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cmd_issue_queue : bench with core memory model and scoreboard  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_cmd_issue_queue;
  import csm_pkg::*;

  localparam int MW = 8, ML = 8, DEPTH = 4, RES_DEPTH = 4, CORE_LAT = 2, TW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready;
  logic [1:0]    in_cmd;
  logic [ML-1:0] in_addA, in_addB, in_addC;
  logic [MW-1:0] in_data;
  logic [TW-1:0] in_tag;
  logic [1:0]    core_cmd;
  logic [ML-1:0] core_addA, core_addB, core_addC;
  logic [MW-1:0] core_DQ_i, core_DQ_o;
  logic          core_issue;
  logic          res_valid, res_ready;
  logic [MW-1:0] res_data;
  logic [TW-1:0] res_tag;
  logic [$clog2(DEPTH):0] q_count;

  cmd_issue_queue #(
    .MEM_WIDTH(MW), .MEM_LENGTH(ML), .DEPTH(DEPTH),
    .RES_DEPTH(RES_DEPTH), .CORE_LAT(CORE_LAT), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_addA(in_addA), .in_addB(in_addB), .in_addC(in_addC),
    .in_data(in_data), .in_tag(in_tag),
    .core_cmd(core_cmd), .core_addA(core_addA), .core_addB(core_addB),
    .core_addC(core_addC), .core_DQ_i(core_DQ_i), .core_issue(core_issue),
    .core_DQ_o(core_DQ_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core: samples the loaded command on the next edge, result valid after it.
  logic [MW-1:0] core_mem [256];
  always @(posedge clk) begin
    case (core_cmd)
      2'b00: core_DQ_o <= core_mem[core_addA];
      2'b01: core_mem[core_addC] <= core_DQ_i;
      2'b10: begin
        core_DQ_o <= core_mem[core_addA] + core_mem[core_addB];
        core_mem[core_addC] <= core_mem[core_addA] + core_mem[core_addB];
      end
      default: begin
        core_DQ_o <= core_mem[core_addA] - core_mem[core_addB];
        core_mem[core_addC] <= core_mem[core_addA] - core_mem[core_addB];
      end
    endcase
  end

  int             checks, errors, issues;
  logic           rr_rand;
  logic [MW-1:0]  mm [256];
  logic [MW-1:0]  mv;
  logic [MW+TW-1:0] exp_q [$];
  logic [MW+TW-1:0] got_q [$];
  logic [MW+TW-1:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: commands take effect in acceptance order on a flat memory.
  initial forever begin
    @(negedge clk);
    if (core_issue === 1'b1) issues++;
    if (rst && in_valid && in_ready) begin
      case (in_cmd)
        2'b00: exp_q.push_back({mm[in_addA], in_tag});
        2'b01: mm[in_addC] = in_data;
        2'b10: begin mv = mm[in_addA] + mm[in_addB]; mm[in_addC] = mv; exp_q.push_back({mv, in_tag}); end
        default: begin mv = mm[in_addA] - mm[in_addB]; mm[in_addC] = mv; exp_q.push_back({mv, in_tag}); end
      endcase
    end
    if (rst && res_valid && res_ready) begin
      got_q.push_back({res_data, res_tag});
      chk("res_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e[MW+TW-1:TW]);
        chk("res_tag", res_tag, e[TW-1:0]);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rr_rand) res_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] d, input logic [7:0] dat, input logic [3:0] t);
    int n = 0;
    in_valid = 1'b1; in_cmd = c; in_addA = a; in_addB = b; in_addC = d;
    in_data = dat; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int c = 0;
    while (got_q.size() < n && c < 200) begin @(posedge clk); #1; c++; end
    chk("wait_results", 32'(got_q.size() >= n), 1);
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] a, b, c, d;
    logic [3:0] tag;
    logic       want;
    logic [7:0] res;
  } vec_t;
  vec_t tbl [11];

  initial begin
    int nexp, k;
    checks = 0; errors = 0; issues = 0; rr_rand = 1'b0;
    for (int i = 0; i < 256; i++) begin core_mem[i] = '0; mm[i] = '0; end
    core_DQ_o = '0;
    rst = 1'b0; in_valid = 1'b1; in_cmd = 2'b01; in_addA = 8'h01; in_addB = 8'h02;
    in_addC = 8'h03; in_data = 8'h5A; in_tag = 4'h1; res_ready = 1'b1;

    // Reset with in_valid held high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_core_issue", core_issue, 0);
    chk("rst_core_cmd", core_cmd, 0);
    chk("rst_core_addr", {core_addA, core_addB, core_addC}, 0);
    chk("rst_core_dq", core_DQ_i, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_tag", res_tag, 0);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_q_count", q_count, 0);

    // Directed vector table
    tbl[0]  = '{2'b01, 8'h00, 8'h00, 8'h00, 8'hAA, 4'h0, 1'b0, 8'h00};
    tbl[1]  = '{2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h3, 1'b1, 8'hAA};
    tbl[2]  = '{2'b01, 8'h00, 8'h00, 8'h00, 8'hAA, 4'h0, 1'b0, 8'h00};
    tbl[3]  = '{2'b01, 8'h00, 8'h00, 8'h01, 8'hAB, 4'h0, 1'b0, 8'h00};
    tbl[4]  = '{2'b10, 8'h00, 8'h01, 8'h04, 8'h00, 4'h1, 1'b1, 8'h55};
    tbl[5]  = '{2'b11, 8'h00, 8'h01, 8'h04, 8'h00, 4'h2, 1'b1, 8'hFF};
    tbl[6]  = '{2'b00, 8'h04, 8'h00, 8'h00, 8'h00, 4'h5, 1'b1, 8'hFF};
    tbl[7]  = '{2'b01, 8'h00, 8'h00, 8'h10, 8'h7F, 4'h0, 1'b0, 8'h00};
    tbl[8]  = '{2'b10, 8'h10, 8'h10, 8'h11, 8'h00, 4'h6, 1'b1, 8'hFE};
    tbl[9]  = '{2'b00, 8'h11, 8'h00, 8'h00, 8'h00, 4'h7, 1'b1, 8'hFE};
    tbl[10] = '{2'b11, 8'h01, 8'h00, 8'h12, 8'h00, 4'h8, 1'b1, 8'h01};
    got_q.delete();
    nexp = 0;
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].tag);
      if (tbl[i].want) nexp++;
    end
    wait_got(nexp);
    k = 0;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].want) begin
        if (k < got_q.size()) begin
          chk("tbl_data", got_q[k][MW+TW-1:TW], tbl[i].res);
          chk("tbl_tag", got_q[k][TW-1:0], tbl[i].tag);
        end
        k++;
      end
    end
    repeat (5) @(posedge clk);
    #1;
    chk("tbl_result_count", got_q.size(), nexp);

    // Credit stall: only RES_DEPTH result-producing commands may be in flight
    res_ready = 1'b0; got_q.delete(); issues = 0;
    for (int i = 0; i < 6; i++) send(2'b00, 8'(i), 8'h00, 8'h00, 8'h00, 4'(i));
    repeat (8) @(posedge clk);
    #1;
    chk("stall_issues", issues, 4);
    chk("stall_q_count", q_count, 2);
    chk("stall_core_issue", core_issue, 0);
    chk("stall_res_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_got(6);
    for (int i = 0; i < 6; i++)
      if (i < got_q.size()) chk("stall_order", got_q[i][TW-1:0], 32'(i));

    // Fill both queues completely with back-to-back pushes
    res_ready = 1'b0; got_q.delete();
    for (int i = 0; i < 8; i++) send(2'b00, 8'h10 + 8'(i), 8'h00, 8'h00, 8'h00, 4'(i));
    repeat (2) @(posedge clk);
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_q_count", q_count, 4);
    res_ready = 1'b1;
    wait_got(8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) chk("full_order", got_q[i][TW-1:0], 32'(i));

    // Reset one edge after an ADD issues discards its result
    send(2'b10, 8'h00, 8'h01, 8'h05, 8'h00, 4'h9);
    @(posedge clk);
    #1;
    chk("mid_issue", core_issue, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("mid_res_valid", res_valid, 0);
    end
    chk("mid_q_count", q_count, 0);
    chk("mid_core_issue", core_issue, 0);
    chk("mid_no_results", got_q.size(), 0);

    // Randomized traffic with random result backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
             8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 4'(i));
      end
    end
    rr_rand = 1'b0;
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin @(posedge clk); #1; end
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_q_count", q_count, 0);
    chk("rand_res_valid", res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
